merge_stage: RTL



---
 rtl/merge_stage_pkg.sv | 15 +
 rtl/merge_arb2.sv | 34 +++
 rtl/merge_stage.sv | 122 ++++++++++++
 3 files changed

// File: rtl/merge_stage_pkg.sv
// Shared constants and types for the two-input packet merge stage.
package merge_stage_pkg;

  localparam int unsigned PackW = 32;

  typedef enum logic [1:0] {
    OIdle = 2'd0,
    OReq  = 2'd1,
    ORtz  = 2'd2
  } out_state_e;

  localparam logic Ch0 = 1'b0;
  localparam logic Ch1 = 1'b1;

endpackage

// File: rtl/merge_arb2.sv
// Combinational two-way round-robin grant; the pointer register lives in the caller.
module merge_arb2
  import merge_stage_pkg::*;
(
  input  logic elig0_i,
  input  logic elig1_i,
  input  logic rr_ptr_i,
  output logic grant0_o,
  output logic grant1_o,
  output logic next_ptr_o
);

  always_comb begin
    grant0_o   = 1'b0;
    grant1_o   = 1'b0;
    next_ptr_o = rr_ptr_i;
    if (elig0_i && elig1_i) begin
      if (rr_ptr_i == Ch0) begin
        grant0_o   = 1'b1;
        next_ptr_o = Ch1;
      end else begin
        grant1_o   = 1'b1;
        next_ptr_o = Ch0;
      end
    end else if (elig0_i) begin
      grant0_o   = 1'b1;
      next_ptr_o = Ch1;
    end else if (elig1_i) begin
      grant1_o   = 1'b1;
      next_ptr_o = Ch0;
    end
  end

endmodule

// File: rtl/merge_stage.sv
// Two-channel 4-phase Send/Ack merge into one output channel through a single packet latch.
module merge_stage
  import merge_stage_pkg::*;
#(
  parameter int unsigned PACK_W = PackW
) (
  input  logic              CLK,
  input  logic              MR_n,
  input  logic              Send_in0,
  output logic              Ack_out0,
  input  logic [PACK_W-1:0] PACKET_IN0,
  input  logic              Send_in1,
  output logic              Ack_out1,
  input  logic [PACK_W-1:0] PACKET_IN1,
  output logic              Send_out,
  input  logic              Ack_in,
  output logic [PACK_W-1:0] PACKET_OUT
);

  logic              ack0_q, ack0_d;
  logic              ack1_q, ack1_d;
  logic              full_q, full_d;
  logic              rr_q, rr_d;
  logic              send_q, send_d;
  logic [PACK_W-1:0] dl_q, dl_d;
  out_state_e        state_q, state_d;

  logic elig0, elig1, grant0, grant1, next_ptr;

  // A channel is locked out until its own return-to-zero completes.
  assign elig0 = Send_in0 & ~ack0_q & ~full_q;
  assign elig1 = Send_in1 & ~ack1_q & ~full_q;

  merge_arb2 u_arb (
    .elig0_i    (elig0),
    .elig1_i    (elig1),
    .rr_ptr_i   (rr_q),
    .grant0_o   (grant0),
    .grant1_o   (grant1),
    .next_ptr_o (next_ptr)
  );

  always_comb begin
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    full_d  = full_q;
    rr_d    = next_ptr;
    send_d  = send_q;
    dl_d    = dl_q;
    state_d = state_q;

    if (grant0) begin
      dl_d   = PACKET_IN0;
      full_d = 1'b1;
      ack0_d = 1'b1;
    end else if (!Send_in0) begin
      ack0_d = 1'b0;
    end

    if (grant1) begin
      dl_d   = PACKET_IN1;
      full_d = 1'b1;
      ack1_d = 1'b1;
    end else if (!Send_in1) begin
      ack1_d = 1'b0;
    end

    // Grants need full_q == 0 and the clear below needs full_q == 1, so they never collide.
    unique case (state_q)
      OIdle: begin
        if (full_q && !Ack_in) begin
          send_d  = 1'b1;
          state_d = OReq;
        end
      end
      OReq: begin
        if (Ack_in) begin
          send_d  = 1'b0;
          full_d  = 1'b0;
          state_d = ORtz;
        end
      end
      ORtz: begin
        if (!Ack_in) begin
          if (full_q) begin
            send_d  = 1'b1;
            state_d = OReq;
          end else begin
            state_d = OIdle;
          end
        end
      end
      default: state_d = OIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge MR_n) begin
    if (!MR_n) begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      full_q  <= 1'b0;
      rr_q    <= Ch0;
      send_q  <= 1'b0;
      dl_q    <= '0;
      state_q <= OIdle;
    end else begin
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      full_q  <= full_d;
      rr_q    <= rr_d;
      send_q  <= send_d;
      dl_q    <= dl_d;
      state_q <= state_d;
    end
  end

  assign Ack_out0   = ack0_q;
  assign Ack_out1   = ack1_q;
  assign Send_out   = send_q;
  assign PACKET_OUT = dl_q;

endmodule
